// File: rtl/i2s_slot_sched_pkg.sv
// Shared constants, tag layout and FSM state type for the I2S slot scheduler.
package i2s_sched_pkg;

   localparam int         TAG_VALID_BIT = 7;
   localparam int         TAG_OVR_BIT   = 6;
   localparam int         TAG_ID_LSB    = 0;
   localparam logic [7:0] TAG_IDLE      = 8'h00;
   localparam int         OVR_CNT_W     = 16;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   // Pad-byte tag for a granted channel: {valid, overrun, 3'b0, id}.
   function automatic logic [7:0] make_tag(input logic ovr, input logic [2:0] id);
      logic [7:0] t;
      t                    = TAG_IDLE;
      t[TAG_VALID_BIT]     = 1'b1;
      t[TAG_OVR_BIT]       = ovr;
      t[TAG_ID_LSB +: 3]   = id;
      return t;
   endfunction

endpackage

// File: rtl/i2s_slot_sched_if.sv
// Channel-strobe inputs and transmit-word outputs of the slot scheduler.
interface i2s_slot_sched_if #(
   parameter int NCH = 4,
   parameter int W   = 24
);
   import i2s_sched_pkg::*;

   logic                 enable;
   logic                 frame_strobe;
   logic [NCH-1:0]       ch_stb;
   logic [NCH*W-1:0]     ch_real;
   logic [NCH*W-1:0]     ch_imag;
   logic [W-1:0]         tx_real;
   logic [W-1:0]         tx_imag;
   logic [7:0]           tx_tag;
   logic [OVR_CNT_W-1:0] ovr_cnt;
   logic [NCH-1:0]       pending;

   modport master (
      output enable, frame_strobe, ch_stb, ch_real, ch_imag,
      input  tx_real, tx_imag, tx_tag, ovr_cnt, pending
   );

   modport slave (
      input  enable, frame_strobe, ch_stb, ch_real, ch_imag,
      output tx_real, tx_imag, tx_tag, ovr_cnt, pending
   );

endinterface

// File: rtl/i2s_slot_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request after the last grant wins.
module rr_arbiter #(
   parameter int NCH = 4,
   parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  last,
   output logic [NCH-1:0] grant,
   output logic [IW-1:0]  id,
   output logic           any
);

   logic [IW-1:0] idx;

   always_comb begin
      grant = '0;
      id    = '0;
      any   = 1'b0;
      idx   = '0;
      // Offsets 1..NCH so the last winner is examined last.
      for (int i = 1; i <= NCH; i++) begin
         idx = IW'((int'(last) + i) % NCH);
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            id         = idx;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2s_slot_sched.sv
// Round-robin sharing of the I2S slot pair between NCH receiver channels,
// one-deep holding register per channel, tagged output word per frame.
module i2s_slot_sched
   import i2s_sched_pkg::*;
#(
   parameter int NCH = 4,
   parameter int W   = 24
) (
   input logic             BCLK,
   input logic             _reset,
   i2s_slot_sched_if.slave bus
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   state_t               state, state_nxt;
   logic [IW-1:0]        ptr, ptr_nxt;
   logic [NCH-1:0]       pending, ovr_flag;
   logic [W-1:0]         hold_real [NCH];
   logic [W-1:0]         hold_imag [NCH];
   logic [NCH-1:0]       arb_grant;
   logic [IW-1:0]        arb_id;
   logic                 arb_any;
   logic                 serve;
   logic [NCH-1:0]       take, ovr_ev;
   logic [W-1:0]         tx_real, tx_imag, tx_real_nxt, tx_imag_nxt;
   logic [7:0]           tx_tag, tx_tag_nxt;
   logic [OVR_CNT_W-1:0] ovr_cnt;

   function automatic logic [OVR_CNT_W-1:0] sat_add(input logic [OVR_CNT_W-1:0] a,
                                                    input logic [NCH-1:0]       ev);
      logic [OVR_CNT_W:0] sum;
      sum = {1'b0, a};
      for (int k = 0; k < NCH; k++) sum = sum + (OVR_CNT_W+1)'(ev[k]);
      return sum[OVR_CNT_W] ? '1 : sum[OVR_CNT_W-1:0];
   endfunction

   rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
      .req   (pending),
      .last  (ptr),
      .grant (arb_grant),
      .id    (arb_id),
      .any   (arb_any)
   );

   // The enable level seen at a strobe decides both the new state and whether
   // that strobe's frame carries data, so frames never split across a change.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      serve       = 1'b0;
      tx_real_nxt = tx_real;
      tx_imag_nxt = tx_imag;
      tx_tag_nxt  = tx_tag;
      if (bus.frame_strobe) begin
         state_nxt   = bus.enable ? ST_RUN : ST_IDLE;
         tx_real_nxt = '0;
         tx_imag_nxt = '0;
         tx_tag_nxt  = TAG_IDLE;
         if (state_nxt == ST_RUN && arb_any) begin
            serve       = 1'b1;
            ptr_nxt     = arb_id;
            tx_real_nxt = hold_real[arb_id];
            tx_imag_nxt = hold_imag[arb_id];
            tx_tag_nxt  = make_tag(ovr_flag[arb_id], 3'(arb_id));
         end
      end
   end

   assign take   = serve ? arb_grant : '0;
   // A strobe on a channel being drained this cycle refills it; not an overrun.
   assign ovr_ev = bus.ch_stb & pending & ~take;

   always_ff @(posedge BCLK or negedge _reset) begin
      if (!_reset) begin
         state    <= ST_IDLE;
         ptr      <= IW'(NCH-1);
         pending  <= '0;
         ovr_flag <= '0;
         ovr_cnt  <= '0;
         tx_real  <= '0;
         tx_imag  <= '0;
         tx_tag   <= TAG_IDLE;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         pending  <= (pending & ~take) | bus.ch_stb;
         ovr_flag <= (ovr_flag & ~take) | ovr_ev | (take & bus.ch_stb & ovr_flag);
         ovr_cnt  <= sat_add(ovr_cnt, ovr_ev);
         tx_real  <= tx_real_nxt;
         tx_imag  <= tx_imag_nxt;
         tx_tag   <= tx_tag_nxt;
      end
   end

   always_ff @(posedge BCLK) begin
      for (int k = 0; k < NCH; k++) begin
         if (bus.ch_stb[k]) begin
            hold_real[k] <= bus.ch_real[k*W +: W];
            hold_imag[k] <= bus.ch_imag[k*W +: W];
         end
      end
   end

   assign bus.tx_real = tx_real;
   assign bus.tx_imag = tx_imag;
   assign bus.tx_tag  = tx_tag;
   assign bus.ovr_cnt = ovr_cnt;
   assign bus.pending = pending;

endmodule

// File: tb/tb_i2s_slot_sched.sv
// Directed bench for i2s_slot_sched: vector table plus corner-case sequences.
module tb_i2s_slot_sched;
   import i2s_sched_pkg::*;

   localparam int NCH = 4;
   localparam int W   = 24;

   logic bclk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   i2s_slot_sched_if #(.NCH(NCH), .W(W)) bus ();

   i2s_slot_sched #(.NCH(NCH), .W(W)) dut (
      .BCLK   (bclk),
      ._reset (rst_n),
      .bus    (bus.slave)
   );

   always #5 bclk = ~bclk;

   typedef struct {
      logic [NCH-1:0] stb;
      logic           fs;
      int             base;
      logic [7:0]     tag;
      int             val;
      logic [NCH-1:0] pend;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Channel k carries real = base+k, imag = -(base+k).
   task automatic drive(input logic [NCH-1:0] stb, input logic fs, input int base);
      for (int k = 0; k < NCH; k++) begin
         if (stb[k]) begin
            bus.ch_real[k*W +: W] = W'(base + k);
            bus.ch_imag[k*W +: W] = W'(-(base + k));
         end
      end
      bus.ch_stb       = stb;
      bus.frame_strobe = fs;
      @(posedge bclk);
      #1;
      bus.ch_stb       = '0;
      bus.frame_strobe = 1'b0;
   endtask

   task automatic check_out(input string nm, input logic [7:0] tag, input int val,
                            input logic [NCH-1:0] pend);
      logic [W-1:0] er, ei;
      er = W'(val);
      ei = W'(-val);
      check({nm, ".tag"},  {24'b0, bus.tx_tag},  {24'b0, tag});
      check({nm, ".real"}, {8'b0, bus.tx_real},  {8'b0, er});
      check({nm, ".imag"}, {8'b0, bus.tx_imag},  {8'b0, ei});
      check({nm, ".pend"}, {28'b0, bus.pending}, {28'b0, pend});
   endtask

   initial begin
      vecs[0]  = '{4'b1111, 1'b0, 100, 8'h00,   0, 4'b1111};
      vecs[1]  = '{4'b0000, 1'b1,   0, 8'h80, 100, 4'b1110};
      vecs[2]  = '{4'b0000, 1'b0,   0, 8'h80, 100, 4'b1110};
      vecs[3]  = '{4'b0000, 1'b1,   0, 8'h81, 101, 4'b1100};
      vecs[4]  = '{4'b0000, 1'b0,   0, 8'h81, 101, 4'b1100};
      vecs[5]  = '{4'b0000, 1'b1,   0, 8'h82, 102, 4'b1000};
      vecs[6]  = '{4'b0000, 1'b0,   0, 8'h82, 102, 4'b1000};
      vecs[7]  = '{4'b0000, 1'b1,   0, 8'h83, 103, 4'b0000};
      vecs[8]  = '{4'b0000, 1'b0,   0, 8'h83, 103, 4'b0000};
      vecs[9]  = '{4'b0000, 1'b1,   0, 8'h00,   0, 4'b0000};
      vecs[10] = '{4'b0100, 1'b0, 200, 8'h00,   0, 4'b0100};
      vecs[11] = '{4'b0000, 1'b1,   0, 8'h82, 202, 4'b0000};
      vecs[12] = '{4'b0000, 1'b0,   0, 8'h82, 202, 4'b0000};
      vecs[13] = '{4'b0000, 1'b1,   0, 8'h00,   0, 4'b0000};

      rst_n            = 1'b0;
      bus.enable       = 1'b0;
      bus.frame_strobe = 1'b0;
      bus.ch_stb       = '0;
      bus.ch_real      = '0;
      bus.ch_imag      = '0;
      repeat (3) @(posedge bclk);
      #1;
      check_out("reset", 8'h00, 0, 4'b0000);
      check("reset.ovr", {16'b0, bus.ovr_cnt}, 32'h0);
      rst_n      = 1'b1;
      bus.enable = 1'b1;
      drive('0, 1'b0, 0);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].stb, vecs[i].fs, vecs[i].base);
         check_out($sformatf("vec%0d", i), vecs[i].tag, vecs[i].val, vecs[i].pend);
      end

      // Double strobe on ch1 before its frame
      drive(4'b0010, 1'b0, 300);
      drive(4'b0010, 1'b0, 400);
      check("ovr.cnt1", {16'b0, bus.ovr_cnt}, 32'h1);
      drive('0, 1'b1, 0);
      check_out("ovr.frame", 8'hC1, 401, 4'b0000);
      drive('0, 1'b0, 0);
      drive(4'b0010, 1'b0, 500);
      drive('0, 1'b1, 0);
      check_out("ovr.next", 8'h81, 501, 4'b0000);
      check("ovr.cnt2", {16'b0, bus.ovr_cnt}, 32'h1);

      // ch3 strobe coinciding with its grant
      drive(4'b1000, 1'b0, 600);
      drive('0, 1'b0, 0);
      drive(4'b1000, 1'b1, 700);
      check_out("same.old", 8'h83, 603, 4'b1000);
      check("same.ovr", {16'b0, bus.ovr_cnt}, 32'h1);
      drive('0, 1'b0, 0);
      drive('0, 1'b1, 0);
      check_out("same.new", 8'h83, 703, 4'b0000);

      // enable dropped mid-frame with all channels pending
      drive(4'b1111, 1'b0, 800);
      drive('0, 1'b1, 0);
      check_out("en.grant", 8'h80, 800, 4'b1110);
      bus.enable = 1'b0;
      repeat (3) drive('0, 1'b0, 0);
      check_out("en.hold", 8'h80, 800, 4'b1110);
      drive('0, 1'b1, 0);
      check_out("en.idle1", 8'h00, 0, 4'b1110);
      drive('0, 1'b0, 0);
      drive('0, 1'b1, 0);
      check_out("en.idle2", 8'h00, 0, 4'b1110);
      bus.enable = 1'b1;
      drive('0, 1'b0, 0);
      drive('0, 1'b1, 0);
      check_out("en.resume", 8'h81, 801, 4'b1100);

      // Asynchronous reset between strobes
      #3;
      rst_n = 1'b0;
      #1;
      check_out("areset", 8'h00, 0, 4'b0000);
      check("areset.ovr", {16'b0, bus.ovr_cnt}, 32'h0);
      #3;
      rst_n = 1'b1;
      drive(4'b1111, 1'b0, 900);
      drive('0, 1'b1, 0);
      check_out("post.first", 8'h80, 900, 4'b1110);

      // Saturation: continuous ch0 strobes with the scheduler stopped
      bus.enable = 1'b0;
      bus.ch_stb = 4'b0001;
      repeat (65535) @(posedge bclk);
      #1;
      check("sat.fffe", {16'b0, bus.ovr_cnt}, 32'hFFFE);
      @(posedge bclk);
      #1;
      check("sat.ffff", {16'b0, bus.ovr_cnt}, 32'hFFFF);
      repeat (100) @(posedge bclk);
      #1;
      check("sat.hold", {16'b0, bus.ovr_cnt}, 32'hFFFF);
      bus.ch_stb = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
